// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, default geometry, phase-counter width.
package uart_pkg;

  typedef enum logic [2:0] {
    UART_RX_IDLE  = 3'd0,
    UART_RX_START = 3'd1,
    UART_RX_DATA  = 3'd2,
    UART_RX_PRTY  = 3'd3,
    UART_RX_STOP  = 3'd4
  } uart_rx_state_e;

  localparam int unsigned UART_OSR_DEF    = 16;
  localparam int unsigned UART_DATA_W_DEF = 8;

  function automatic int unsigned uart_phase_w(input int unsigned osr);
    return $clog2(osr);
  endfunction

  localparam int unsigned UART_PHASE_W_DEF = uart_phase_w(UART_OSR_DEF);

endpackage

// File: rtl/uart_rx_core_if.sv
// Register-side bundle of the UART receiver: control inputs, read/clear strobes, status.
interface uart_rx_core_if
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = UART_DATA_W_DEF
);
  logic              uart_en;
  logic [15:0]       uart_baud;
  logic              uart_prty_en;
  logic              uart_rxbuf_rd;
  logic              uart_rxpnd_clr;
  logic [DATA_W-1:0] uart_rxbuf;
  logic              uart_rx9;
  logic              uart_rxpnd;
  logic              uart_rx_ovf;
  logic              uart_rx_ferr;
  logic              uart_rx_busy;

  modport master (
    output uart_en, uart_baud, uart_prty_en, uart_rxbuf_rd, uart_rxpnd_clr,
    input  uart_rxbuf, uart_rx9, uart_rxpnd, uart_rx_ovf, uart_rx_ferr, uart_rx_busy
  );

  modport slave (
    input  uart_en, uart_baud, uart_prty_en, uart_rxbuf_rd, uart_rxpnd_clr,
    output uart_rxbuf, uart_rx9, uart_rxpnd, uart_rx_ovf, uart_rx_ferr, uart_rx_busy
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one tick every baud+1 cycles, shared by the RX and TX paths.
module uart_baud_tick #(
  parameter int unsigned W = 16
) (
  input  logic         sys_clk,
  input  logic         sys_rstn,
  input  logic         en,
  input  logic [W-1:0] baud,
  output logic         tick
);

  logic [W-1:0] cnt;
  logic [W-1:0] lim;

  assign tick = en && (cnt == lim);

  // The limit is latched only at a wrap (or while idle) so a divisor change never truncates a period.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      cnt <= '0;
      lim <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
      lim <= baud;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receive path: synchronizer, oversampling FSM, receive buffer and status flags.
// Optional 2-of-3 majority sampling is selected by defining UART_RX_MAJORITY_EN.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned OSR    = UART_OSR_DEF,
  parameter int unsigned DATA_W = UART_DATA_W_DEF
) (
  input  logic           sys_clk,
  input  logic           sys_rstn,
  input  logic           uart_rx,
  uart_rx_core_if.slave  bus
);

  localparam int unsigned PH_W  = uart_phase_w(OSR);
  localparam int unsigned IDX_W = $clog2(DATA_W + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  logic                rx_meta, rx_sync;
  logic                tick;
  uart_rx_state_e      state, state_nxt;
  logic [PH_W-1:0]     phase;
  logic [IDX_W-1:0]    bit_idx;
  logic [DATA_W-1:0]   shreg;
  logic                p_bit;
  logic                sample, at_dec, load;
  logic [DATA_W-1:0]   rxbuf;
  logic                rx9, pnd, ovf, ferr, busy;

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
    end
  end

  uart_baud_tick #(.W(16)) u_tick (
    .sys_clk  (sys_clk),
    .sys_rstn (sys_rstn),
    .en       (bus.uart_en),
    .baud     (bus.uart_baud),
    .tick     (tick)
  );

`ifdef UART_RX_MAJORITY_EN
  localparam logic [PH_W-1:0] PH_DEC = PH_W'(OSR / 2 + 1);
  localparam logic [PH_W-1:0] PH_S0  = PH_W'(OSR / 2 - 1);
  localparam logic [PH_W-1:0] PH_S1  = PH_W'(OSR / 2);
  logic s0, s1;

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      s0 <= 1'b1;
      s1 <= 1'b1;
    end else if (tick) begin
      if (phase == PH_S0) s0 <= rx_sync;
      if (phase == PH_S1) s1 <= rx_sync;
    end
  end

  assign sample = (s0 & s1) | (s0 & rx_sync) | (s1 & rx_sync);
`else
  localparam logic [PH_W-1:0] PH_DEC = PH_W'(OSR / 2);
  assign sample = rx_sync;
`endif

  assign at_dec = tick && (phase == PH_DEC);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    if (!bus.uart_en) begin
      state_nxt = UART_RX_IDLE;
    end else begin
      unique case (state)
        UART_RX_IDLE:  if (tick && !rx_sync) state_nxt = UART_RX_START;
        UART_RX_START: if (at_dec) state_nxt = sample ? UART_RX_IDLE : UART_RX_DATA;
        UART_RX_DATA:  if (at_dec && bit_idx == LAST_IDX)
                         state_nxt = bus.uart_prty_en ? UART_RX_PRTY : UART_RX_STOP;
        UART_RX_PRTY:  if (at_dec) state_nxt = UART_RX_STOP;
        UART_RX_STOP:  if (at_dec) begin
                         state_nxt = UART_RX_IDLE;
                         load      = 1'b1;
                       end
        default:       state_nxt = UART_RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state   <= UART_RX_IDLE;
      busy    <= 1'b0;
      phase   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      p_bit   <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != UART_RX_IDLE);
      if (!bus.uart_en) begin
        phase   <= '0;
        bit_idx <= '0;
      end else if (tick) begin
        // Phase is parked at 0 while idle, so the detection tick hands START a phase of 0.
        phase <= (state == UART_RX_IDLE) ? '0 : phase + 1'b1;
        if (at_dec) begin
          unique case (state)
            UART_RX_START: bit_idx <= '0;
            UART_RX_DATA: begin
              shreg   <= {sample, shreg[DATA_W-1:1]};
              bit_idx <= (bit_idx == LAST_IDX) ? '0 : bit_idx + 1'b1;
            end
            UART_RX_PRTY:  p_bit <= sample;
            default: ;
          endcase
        end
      end
    end
  end

  // Set always wins over a same-cycle clear.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      rxbuf <= '0;
      rx9   <= 1'b0;
      pnd   <= 1'b0;
      ovf   <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      if (load) begin
        rxbuf <= shreg;
        rx9   <= bus.uart_prty_en & p_bit;
      end
      pnd  <= load | (pnd & ~(bus.uart_rxbuf_rd | bus.uart_rxpnd_clr));
      ovf  <= (load & pnd) | (ovf & ~bus.uart_rxpnd_clr);
      ferr <= (load & ~sample) | (ferr & ~bus.uart_rxpnd_clr);
    end
  end

  assign bus.uart_rxbuf   = rxbuf;
  assign bus.uart_rx9     = rx9;
  assign bus.uart_rxpnd   = pnd;
  assign bus.uart_rx_ovf  = ovf;
  assign bus.uart_rx_ferr = ferr;
  assign bus.uart_rx_busy = busy;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed self-checking bench for uart_rx_core: frames driven bit by bit on the serial line.
module tb_uart_rx_core;

  logic clk;
  logic rstn;
  logic rx;
  int unsigned n_cmp;
  int unsigned n_err;

  uart_rx_core_if #(.DATA_W(8)) bus ();

  uart_rx_core #(.OSR(16), .DATA_W(8)) dut (
    .sys_clk  (clk),
    .sys_rstn (rstn),
    .uart_rx  (rx),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic line_bit(input logic b, input int unsigned bp);
    rx = b;
    repeat (bp) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic par, input logic p,
                      input logic stop, input int unsigned bp);
    line_bit(1'b0, bp);
    for (int i = 0; i < 8; i++) line_bit(d[i], bp);
    if (par) line_bit(p, bp);
    line_bit(stop, bp);
    rx = 1'b1;
  endtask

  task automatic pulse_clr();
    bus.uart_rxpnd_clr = 1'b1;
    @(negedge clk);
    bus.uart_rxpnd_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_rd();
    bus.uart_rxbuf_rd = 1'b1;
    @(negedge clk);
    bus.uart_rxbuf_rd = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rstn  = 1'b0;
    rx    = 1'b1;
    bus.uart_en        = 1'b0;
    bus.uart_baud      = 16'd0;
    bus.uart_prty_en   = 1'b0;
    bus.uart_rxbuf_rd  = 1'b0;
    bus.uart_rxpnd_clr = 1'b0;
    idle(3);
    rstn = 1'b1;
    idle(1);

    chk("rst_rxbuf", 32'(bus.uart_rxbuf), 32'h00);
    chk("rst_rx9",   32'(bus.uart_rx9),   32'h0);
    chk("rst_pnd",   32'(bus.uart_rxpnd), 32'h0);
    chk("rst_ovf",   32'(bus.uart_rx_ovf), 32'h0);
    chk("rst_ferr",  32'(bus.uart_rx_ferr), 32'h0);
    chk("rst_busy",  32'(bus.uart_rx_busy), 32'h0);

    bus.uart_en = 1'b1;
    idle(5);

    // 8N1 0xA5 at baud 0
    send(8'hA5, 1'b0, 1'b0, 1'b1, 16);
    idle(20);
    chk("a5_rxbuf", 32'(bus.uart_rxbuf), 32'hA5);
    chk("a5_pnd",   32'(bus.uart_rxpnd), 32'h1);
    chk("a5_ferr",  32'(bus.uart_rx_ferr), 32'h0);
    chk("a5_ovf",   32'(bus.uart_rx_ovf), 32'h0);
    chk("a5_rx9",   32'(bus.uart_rx9), 32'h0);
    chk("a5_busy",  32'(bus.uart_rx_busy), 32'h0);
    pulse_clr();

    // 9-bit frame 0x3C with 9th bit 1
    bus.uart_prty_en = 1'b1;
    send(8'h3C, 1'b1, 1'b1, 1'b1, 16);
    idle(20);
    chk("p_rxbuf", 32'(bus.uart_rxbuf), 32'h3C);
    chk("p_rx9",   32'(bus.uart_rx9), 32'h1);
    chk("p_pnd",   32'(bus.uart_rxpnd), 32'h1);
    bus.uart_prty_en = 1'b0;
    pulse_clr();
    chk("p_clr_pnd", 32'(bus.uart_rxpnd), 32'h0);

    // 4-tick low glitch on an idle line
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(2);
    chk("gl_busy_hi", 32'(bus.uart_rx_busy), 32'h1);
    idle(20);
    chk("gl_busy_lo", 32'(bus.uart_rx_busy), 32'h0);
    chk("gl_pnd",     32'(bus.uart_rxpnd), 32'h0);
    chk("gl_rxbuf",   32'(bus.uart_rxbuf), 32'h3C);

    // 0x55 with a zero stop bit
    send(8'h55, 1'b0, 1'b0, 1'b0, 16);
    idle(40);
    chk("fe_rxbuf", 32'(bus.uart_rxbuf), 32'h55);
    chk("fe_pnd",   32'(bus.uart_rxpnd), 32'h1);
    chk("fe_ferr",  32'(bus.uart_rx_ferr), 32'h1);
    pulse_clr();
    chk("fe_clr_pnd",  32'(bus.uart_rxpnd), 32'h0);
    chk("fe_clr_ovf",  32'(bus.uart_rx_ovf), 32'h0);
    chk("fe_clr_ferr", 32'(bus.uart_rx_ferr), 32'h0);

    // back-to-back 0x11, 0x22 without a read
    send(8'h11, 1'b0, 1'b0, 1'b1, 16);
    send(8'h22, 1'b0, 1'b0, 1'b1, 16);
    idle(20);
    chk("ov_rxbuf", 32'(bus.uart_rxbuf), 32'h22);
    chk("ov_ovf",   32'(bus.uart_rx_ovf), 32'h1);
    chk("ov_pnd",   32'(bus.uart_rxpnd), 32'h1);
    chk("ov_ferr",  32'(bus.uart_rx_ferr), 32'h0);
    pulse_rd();
    chk("ov_rd_pnd", 32'(bus.uart_rxpnd), 32'h0);
    chk("ov_rd_ovf", 32'(bus.uart_rx_ovf), 32'h1);
    pulse_clr();

    // slower divisor: 2 cycles per tick, 32 cycles per bit
    bus.uart_baud = 16'd1;
    idle(2);
    send(8'h96, 1'b0, 1'b0, 1'b1, 32);
    idle(60);
    chk("b1_rxbuf", 32'(bus.uart_rxbuf), 32'h96);
    chk("b1_pnd",   32'(bus.uart_rxpnd), 32'h1);
    bus.uart_baud = 16'd0;
    pulse_clr();
    idle(4);

    // enable dropped mid-byte, then a full 0x7E
    line_bit(1'b0, 16);
    line_bit(1'b0, 16);
    line_bit(1'b1, 16);
    line_bit(1'b1, 16);
    bus.uart_en = 1'b0;
    idle(2);
    chk("en_busy", 32'(bus.uart_rx_busy), 32'h0);
    rx = 1'b1;
    idle(200);
    chk("en_pnd",   32'(bus.uart_rxpnd), 32'h0);
    chk("en_rxbuf", 32'(bus.uart_rxbuf), 32'h96);
    bus.uart_en = 1'b1;
    idle(5);
    send(8'h7E, 1'b0, 1'b0, 1'b1, 16);
    idle(20);
    chk("re_rxbuf", 32'(bus.uart_rxbuf), 32'h7E);
    chk("re_pnd",   32'(bus.uart_rxpnd), 32'h1);
    chk("re_ferr",  32'(bus.uart_rx_ferr), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
